ram_text_streamer: RTL and testbench
====================================

# ram_text_streamer

Read-side companion to the dual-port character RAM: on a start pulse it scans every row and column of the RAM through the read port and streams each stored byte out over a valid/ready byte interface. The stream typically feeds the UART transmitter. It accounts for the RAM's one-cycle registered read latency and back-pressure from the sink. An optional CR/LF terminator follows each row.

## Interface
- `DATA_WIDTH`, 8, width of each character; must match RAM.
- `ROWS`, 4, RAM rows; power of two, ≥2.
- `COLS`, 32, RAM columns; power of two, ≥2.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request to stream the whole RAM; ignored while `busy`.
- `r_row`  out  $clog2(ROWS)  RAM read row address; registered.
- `r_col`  out  $clog2(COLS)  RAM read column address; registered.
- `ram_dout`  in  DATA_WIDTH  RAM read data, valid one cycle after address.
- `tx_data`  out  DATA_WIDTH  byte to sink; registered.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  sink accepts; transfer when `tx_valid && tx_ready` at a rising edge.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse after the final byte transfers.

## Operation
- States: IDLE, RD, LATCH, SEND, CR, LF, DONE.
- IDLE: `start=1` -> row=0, col=0, `busy<=1`, go to RD.
- RD: `r_row`/`r_col` present the current address. Go to LATCH.
- LATCH: `ram_dout` is valid. `tx_data<=ram_dout`, `tx_valid<=1`. Go to SEND.
- SEND: hold `tx_data` and `tx_valid` until the handshake. On handshake `tx_valid<=0`, then:
  - col<COLS-1: col+1, go to RD.
  - col==COLS-1 with the EOL feature: go to CR.
  - col==COLS-1 without it, row<ROWS-1: row+1, col=0, go to RD.
  - col==COLS-1 without it, row==ROWS-1: go to DONE.
- CR: `tx_data=0x0D` valid until the handshake, then go to LF.
- LF: `tx_data=0x0A` valid until the handshake. Then row<ROWS-1: row+1, col=0, go to RD; otherwise go to DONE.
- DONE: `done<=1` for one cycle, `busy<=0`, return to IDLE. `start` in the DONE cycle is ignored.
- Bytes are transmitted raw, including 0x00 (RAM reset value). No filtering.
- Row and column counters wrap only via the explicit transitions above. There is no modulo overflow.
- `tx_data` must not change while `tx_valid && !tx_ready`.
- `tx_ready` asserted while `tx_valid=0` has no effect.
- Reset mid-frame: immediately return to IDLE and abandon the frame. No `done` pulse is issued.
- Reset values: `r_row=0`, `r_col=0`, `tx_data=0`, `tx_valid=0`, `busy=0`, `done=0`, state=IDLE.

## Timing
- `start` sampled at edge E0 -> RD during E0..E1 -> LATCH E1..E2 -> `tx_valid` high from E2.
- First-byte latency: 2 cycles after the `start` edge.
- Throughput with `tx_ready` tied high: 3 cycles per character (SEND, RD, LATCH). CR and LF take 1 cycle each.
- Frame length: ROWS×COLS bytes, plus 2×ROWS bytes with the EOL feature.
- `done` rises the cycle after the last handshake.
- `busy` falls together with the `done` pulse.
- A concurrent RAM write to the address being read is resolved by the RAM. The streamer sends whatever `ram_dout` holds in LATCH.

## Configuration
- `STREAM_EOL_EN` defined: CR and LF states are compiled in; 0x0D, 0x0A follows every row, including the last.
- `STREAM_EOL_EN` undefined: CR and LF are absent; rows are concatenated; frame is ROWS×COLS bytes.

## Test plan
- Cleared RAM, `tx_ready=1`, EOL off, `start` pulse:
  - 128 bytes of 0x00;
  - `tx_valid` first high 2 cycles after `start`;
  - `done` pulses 1 cycle after the 128th handshake, 3×128 cycles total.
- RAM row r, col c loaded with 0x41+c (c<26), EOL on:
  - stream per row is "A".."Z", six more bytes, then 0x0D 0x0A;
  - 136 bytes total; address order is row-major.
- Back-pressure: `tx_ready` random 30% duty:
  - `tx_data` stable while stalled;
  - byte sequence identical to the no-stall run;
  - no byte dropped or duplicated.
- `start` pulsed again mid-frame and during DONE: ignored; exactly one `done` pulse; frame unchanged.
- `reset` asserted while streaming row 2:
  - next cycle all outputs at reset values;
  - a fresh `start` restarts from (0,0).
- Edge address: only mem[3][31]=0x5A, others 0x00:
  - 0x5A is the final byte (EOL off) or the third-from-last (EOL on);
  - `r_row`/`r_col` never exceed 3/31.

Source files
------------

// File: rtl/ram_text_streamer.sv
// Scans the character RAM row-major through its read port and streams each byte over valid/ready.
// Define STREAM_EOL_EN to append CR (0x0D) and LF (0x0A) after every row.
module ram_text_streamer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [$clog2(ROWS)-1:0]  r_row,
  output logic [$clog2(COLS)-1:0]  r_col,
  input  logic [DATA_WIDTH-1:0]    ram_dout,
  output logic [DATA_WIDTH-1:0]    tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned RowW = $clog2(ROWS);
  localparam int unsigned ColW = $clog2(COLS);
  localparam logic [RowW-1:0] RowLast = RowW'(ROWS - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(COLS - 1);
`ifdef STREAM_EOL_EN
  localparam logic [DATA_WIDTH-1:0] CharCr = DATA_WIDTH'(8'h0D);
  localparam logic [DATA_WIDTH-1:0] CharLf = DATA_WIDTH'(8'h0A);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StLatch,
    StSend,
`ifdef STREAM_EOL_EN
    StCr,
    StLf,
`endif
    StDone
  } state_e;

  state_e r_state;

  logic w_hs;
  logic w_col_last;
  logic w_row_last;

  assign w_hs       = tx_valid && tx_ready;
  assign w_col_last = (r_col == ColLast);
  assign w_row_last = (r_row == RowLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_row    <= '0;
      r_col    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_row   <= '0;
            r_col   <= '0;
            busy    <= 1'b1;
            r_state <= StRd;
          end
        end
        // Address is on r_row/r_col this cycle; the RAM registers it at the next edge.
        StRd: r_state <= StLatch;
        StLatch: begin
          tx_data  <= ram_dout;
          tx_valid <= 1'b1;
          r_state  <= StSend;
        end
        StSend: begin
          if (w_hs) begin
            if (!w_col_last) begin
              tx_valid <= 1'b0;
              r_col    <= r_col + 1'b1;
              r_state  <= StRd;
            end else begin
`ifdef STREAM_EOL_EN
              // Keep tx_valid high so CR goes out in the very next cycle.
              tx_data <= CharCr;
              r_state <= StCr;
`else
              tx_valid <= 1'b0;
              if (!w_row_last) begin
                r_row   <= r_row + 1'b1;
                r_col   <= '0;
                r_state <= StRd;
              end else begin
                done    <= 1'b1;
                busy    <= 1'b0;
                r_state <= StDone;
              end
`endif
            end
          end
        end
`ifdef STREAM_EOL_EN
        StCr: begin
          if (w_hs) begin
            tx_data <= CharLf;
            r_state <= StLf;
          end
        end
        StLf: begin
          if (w_hs) begin
            tx_valid <= 1'b0;
            if (!w_row_last) begin
              r_row   <= r_row + 1'b1;
              r_col   <= '0;
              r_state <= StRd;
            end else begin
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= StDone;
            end
          end
        end
`endif
        // done is high for exactly this cycle; start here is dropped.
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_text_streamer.sv
// Directed bench for ram_text_streamer with a behavioural registered-read RAM.
module tb_ram_text_streamer;

  localparam int ROWS = 4;
  localparam int COLS = 32;
`ifdef STREAM_EOL_EN
  localparam int EOL_EXTRA = 2 * ROWS;
`else
  localparam int EOL_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] r_row;
  logic [4:0] r_col;
  logic [7:0] ram_dout;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic       done;

  logic [7:0] mem [ROWS][COLS];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int e0 = 0;
  int first_v_cyc = -1;
  int last_hs_cyc = -1;
  int done_cyc = -1;
  int done_cnt = 0;
  int max_row = 0;
  int max_col = 0;
  bit rand_mode = 1'b0;
  bit stall_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];

  ram_text_streamer #(
    .DATA_WIDTH(8),
    .ROWS      (ROWS),
    .COLS      (COLS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .r_row   (r_row),
    .r_col   (r_col),
    .ram_dout(ram_dout),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ram_dout <= mem[r_row][r_col];

  // Sink: ready high 30% of cycles in random mode, otherwise always ready.
  always @(posedge clk) begin
    #1;
    tx_ready = rand_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (stall_prev) begin
        check_eq("hold_valid", 32'(tx_valid), 32'd1);
        check_eq("hold_data", 32'(tx_data), 32'(data_prev));
      end
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        last_hs_cyc = cyc + 1;
      end
      if (tx_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (int'(r_row) > max_row) max_row = int'(r_row);
      if (int'(r_col) > max_col) max_col = int'(r_col);
    end
    stall_prev = !reset && tx_valid && !tx_ready;
    data_prev  = tx_data;
  end

  task automatic fill(input int kind);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (kind == 1) mem[r][c] = (c < 26) ? 8'(8'h41 + c) : 8'(8'h30 + r);
        else mem[r][c] = 8'h00;
      end
    end
    if (kind == 2) mem[ROWS-1][COLS-1] = 8'h5A;
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) exp_q.push_back(mem[r][c]);
`ifdef STREAM_EOL_EN
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
`endif
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    e0 = cyc + 1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic begin_frame();
    got_q.delete();
    first_v_cyc = -1;
    max_row = 0;
    max_col = 0;
    pulse_start();
  endtask

  task automatic wait_done(input string tag, input int target);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done_cnt >= target) break;
    end
    check_eq({tag, "_done_seen"}, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic cmp_frame(input string tag);
    int n;
    check_eq({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int tgt;
    int cnt5a;
    fill(0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_row", 32'(r_row), 32'd0);
    check_eq("rst_col", 32'(r_col), 32'd0);
    check_eq("rst_data", 32'(tx_data), 32'd0);
    check_eq("rst_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);

    // Cleared RAM, sink always ready: latency, frame length and timing.
    build_exp();
    tgt = done_cnt + 1;
    begin_frame();
    @(negedge clk);
    check_eq("busy_after_start", 32'(busy), 32'd1);
    wait_done("clr", tgt);
    cmp_frame("clr");
    check_eq("first_valid_lat", 32'(first_v_cyc - e0), 32'd2);
    check_eq("done_after_last_hs", 32'(done_cyc), 32'(last_hs_cyc));
    check_eq("frame_cycles", 32'(done_cyc - e0), 32'(3 * ROWS * COLS + EOL_EXTRA));
    @(negedge clk);
    check_eq("busy_after_done", 32'(busy), 32'd0);
    check_eq("done_one_cycle", 32'(done), 32'd0);

    // Letter pattern, ready always high.
    fill(1);
    build_exp();
    tgt = done_cnt + 1;
    begin_frame();
    wait_done("pat", tgt);
    cmp_frame("pat");

    // Same pattern under random back-pressure.
    rand_mode = 1'b1;
    tgt = done_cnt + 1;
    begin_frame();
    wait_done("bp", tgt);
    cmp_frame("bp");
    rand_mode = 1'b0;

    // Extra start pulses mid-frame and in the DONE cycle are ignored.
    tgt = done_cnt + 1;
    begin_frame();
    repeat (100) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("restart_done_cnt", 32'(done_cnt), 32'(tgt));
    check_eq("restart_busy", 32'(busy), 32'd0);
    cmp_frame("restart");

    // Reset while streaming row 2 abandons the frame.
    tgt = done_cnt;
    begin_frame();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (r_row == 2'd2) break;
    end
    check_eq("reached_row2", 32'(r_row), 32'd2);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_rst_row", 32'(r_row), 32'd0);
    check_eq("mid_rst_col", 32'(r_col), 32'd0);
    check_eq("mid_rst_data", 32'(tx_data), 32'd0);
    check_eq("mid_rst_valid", 32'(tx_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("no_done_on_reset", 32'(done_cnt), 32'(tgt));
    tgt = done_cnt + 1;
    begin_frame();
    wait_done("fresh", tgt);
    cmp_frame("fresh");

    // Only the last cell is non-zero.
    fill(2);
    build_exp();
    tgt = done_cnt + 1;
    begin_frame();
    wait_done("edge", tgt);
    cmp_frame("edge");
    cnt5a = 0;
    foreach (got_q[i]) if (got_q[i] == 8'h5A) cnt5a++;
    check_eq("edge_5a_count", 32'(cnt5a), 32'd1);
    if (got_q.size() >= 1 + EOL_EXTRA / ROWS)
      check_eq("edge_5a_pos", 32'(got_q[got_q.size() - 1 - EOL_EXTRA / ROWS]), 32'h5A);
    else
      check_eq("edge_5a_pos_len", 32'(got_q.size()), 32'(1 + EOL_EXTRA / ROWS));
    check_eq("edge_max_row", 32'(max_row), 32'(ROWS - 1));
    check_eq("edge_max_col", 32'(max_col), 32'(COLS - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
